square_51_accum: RTL

Pipelined accumulator that consumes the partial-product terms emitted by the 51-bit limb squarer and reassembles the full 102-bit square. It sits immediately downstream of the 3×17-bit-limb squaring multiplier array in the modular-square datapath. It applies the doubling and limb-offset weighting of the cross terms, and presents the result under a valid/ready handshake with back-pressure.

---
 rtl/square_51_accum.sv | 90 +++++++++
 1 files changed

// File: rtl/square_51_accum.sv
// Three-stage accumulator that rebuilds the 102-bit square of a 51-bit value
// from the limb partial products, with valid/ready flow control and a delivery counter.
module square_51_accum (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [33:0]  term_34w,
  input  logic [67:0]  term_68w,
  input  logic [101:0] term_102w,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [101:0] out_sq,
  output logic [15:0]  result_count
);

  logic         adv;
  logic         v1, v2, v3;

  logic [101:0] op_a, op_b, op_c;
  logic [101:0] csa_sum, csa_carry;
  logic [101:0] s1_sum, s1_carry;

  logic [51:0]  lo_sum;
  logic [50:0]  s2_lo, s2_sum_hi, s2_carry_hi;
  logic         s2_cy;

  logic [50:0]  hi_sum;

  // A single enable stalls every stage together, bubbles included.
  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;

  // Cross terms carry the doubling in their shift: x1*x0 and x2*x1 land at
  // 2^18 / 2^52, x2*x0 at 2^35.
  always_comb begin
    op_a      = term_102w;
    op_b      = {16'b0, term_68w, 18'b0};
    op_c      = {33'b0, term_34w, 35'b0};
    csa_sum   = op_a ^ op_b ^ op_c;
    csa_carry = {((op_a[100:0] & op_b[100:0]) |
                  (op_a[100:0] & op_c[100:0]) |
                  (op_b[100:0] & op_c[100:0])), 1'b0};
    lo_sum    = {1'b0, s1_sum[50:0]} + {1'b0, s1_carry[50:0]};
    hi_sum    = s2_sum_hi + s2_carry_hi + {50'b0, s2_cy};
  end

  // NOTE: reset is sampled on the clock edge only, and every register is
  // written with non-blocking assignments so all stages see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      v3           <= 1'b0;
      s1_sum       <= '0;
      s1_carry     <= '0;
      s2_lo        <= '0;
      s2_cy        <= 1'b0;
      s2_sum_hi    <= '0;
      s2_carry_hi  <= '0;
      out_sq       <= '0;
      result_count <= '0;
    end else begin
      if (adv) begin
        v1 <= in_valid;
        v2 <= v1;
        v3 <= v2;
        // Data only moves with a valid token, so a bubble leaves the stage unchanged.
        if (in_valid) begin
          s1_sum   <= csa_sum;
          s1_carry <= csa_carry;
        end
        if (v1) begin
          s2_lo       <= lo_sum[50:0];
          s2_cy       <= lo_sum[51];
          s2_sum_hi   <= s1_sum[101:51];
          s2_carry_hi <= s1_carry[101:51];
        end
        if (v2) begin
          out_sq <= {hi_sum, s2_lo};
        end
      end
      if (v3 && out_ready) begin
        result_count <= result_count + 16'd1;
      end
    end
  end

endmodule
